req_issue_queue: RTL

REQ_ISSUE_QUEUE -- requirements
Module: req_issue_queue

---
 rtl/req_issue_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/req_issue_queue.sv
// Request issue queue: FIFO of {op, addr} requests feeding a one-at-a-time issue FSM.
// Latency: a push into an empty idle queue issues (valid) in the cycle after the next edge.
// Backpressure: in_ready drops when DEPTH entries are held; while full, in_valid is ignored.
module req_issue_queue #(
  parameter int DEPTH   = 8,    // power of two, >= 2
  parameter int OP_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255   // >= 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [OP_W-1:0]         in_op,
  input  logic [ADDR_W-1:0]       in_addr,
  output logic                    in_ready,
  output logic                    valid,
  output logic [OP_W-1:0]         op,
  output logic [ADDR_W-1:0]       addr,
  input  logic                    opr_finished,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    timeout_err,
  output logic                    spurious_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  // The counter is compared before it increments, so the last WAIT cycle sees TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_valid;
  logic                r_busy;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_timeout_err;
  logic                r_spurious_err;

  logic [OP_W-1:0]     r_op_mem   [DEPTH];
  logic [ADDR_W-1:0]   r_addr_mem [DEPTH];

  logic                w_push;
  logic                w_pop;

  // Handshakes are derived from registered state only, so in_ready has no input-to-output path.
  assign in_ready = (r_count < FULL_CNT);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

  assign valid        = r_valid;
  assign busy         = r_busy;
  assign op           = r_op;
  assign addr         = r_addr;
  assign count        = r_count;
  assign timeout_err  = r_timeout_err;
  assign spurious_err = r_spurious_err;

  // Queue storage: written on push, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]   <= in_op;
      r_addr_mem[r_wr_ptr] <= in_addr;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: pop in IDLE, strobe valid in ISSUE, wait for completion or abandon in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_valid        <= 1'b0;
      r_busy         <= 1'b0;
      r_op           <= '0;
      r_addr         <= '0;
      r_timeout_err  <= 1'b0;
      r_spurious_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (opr_finished) r_spurious_err <= 1'b1;
          if (w_pop) begin
            r_op       <= r_op_mem[r_rd_ptr];
            r_addr     <= r_addr_mem[r_rd_ptr];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (opr_finished) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (opr_finished) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
